// File: rtl/mix_col_sched_pkg.sv
// Shared definitions for the MixColumns scheduler: FSM encoding, state
// geometry and the GF(2^8) doubling helper used by the column mixer.
package mix_col_sched_pkg;

  localparam int NUM_COLS = 4;
  localparam int COL_W    = 32;
  localparam int STATE_W  = 128;
  localparam int CIDX_W   = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MIX  = 2'd1,
    S_DONE = 2'd2
  } sched_state_t;

  // Multiply a byte by x (0x02) in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/GF_2_8_multiplier.sv
// Single-column AES MixColumns: four bytes in, four mixed bytes out.
// Byte 0 of the column occupies the most significant byte.
module GF_2_8_multiplier
  import mix_col_sched_pkg::*;
(
  input  logic [31:0] i_col,
  output logic [31:0] o_col
);

  logic [7:0] w_b0, w_b1, w_b2, w_b3;
  logic [7:0] w_x0, w_x1, w_x2, w_x3;

  assign w_b0 = i_col[31:24];
  assign w_b1 = i_col[23:16];
  assign w_b2 = i_col[15:8];
  assign w_b3 = i_col[7:0];

  assign w_x0 = xtime(w_b0);
  assign w_x1 = xtime(w_b1);
  assign w_x2 = xtime(w_b2);
  assign w_x3 = xtime(w_b3);

  // Each output byte is {2,3,1,1} rotated; 3*b is expressed as xtime(b) ^ b.
  always_comb begin
    o_col[31:24] = w_x0 ^ (w_x1 ^ w_b1) ^ w_b2 ^ w_b3;
    o_col[23:16] = w_b0 ^ w_x1 ^ (w_x2 ^ w_b2) ^ w_b3;
    o_col[15:8]  = w_b0 ^ w_b1 ^ w_x2 ^ (w_x3 ^ w_b3);
    o_col[7:0]   = (w_x0 ^ w_b0) ^ w_b1 ^ w_b2 ^ w_x3;
  end

endmodule

// File: rtl/mix_col_sched.sv
// MixColumns scheduler: accepts one 128-bit AES state, runs it through a
// single shared column mixer one column per cycle, then holds the result
// until downstream takes it. Final-round blocks may bypass the mixing.
module mix_col_sched
  import mix_col_sched_pkg::*;
#(
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [0:127]   in_data,
  input  logic           bypass,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [0:127]   out_data,
  output logic           busy
);

  sched_state_t        r_state;
  sched_state_t        w_next_state;
  logic [CIDX_W-1:0]   r_col_idx;
  logic [0:STATE_W-1]  r_in_data;
  logic [0:STATE_W-1]  r_out_data;
  logic [COL_W-1:0]    w_col_in;
  logic [COL_W-1:0]    w_col_mixed;
  logic [6:0]          w_col_base;
  logic                w_bypass;
  logic                w_in_ready;
  logic                w_out_valid;
  logic                w_busy;

  assign w_bypass   = BYPASS_EN && bypass;
  assign w_col_base = {r_col_idx, 5'b0_0000};

  // 4:1 column mux feeding the shared mixer.
  assign w_col_in = r_in_data[w_col_base +: COL_W];

  GF_2_8_multiplier u_gf_2_8_multiplier (
    .i_col (w_col_in),
    .o_col (w_col_mixed)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state and handshake outputs.
  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    w_busy       = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b0;
        if (in_valid) w_next_state = w_bypass ? S_DONE : S_MIX;
      end
      S_MIX: begin
        if (r_col_idx == CIDX_W'(NUM_COLS - 1)) w_next_state = S_DONE;
      end
      S_DONE: begin
        w_out_valid = 1'b1;
        if (out_ready) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Datapath: capture on accept, write one mixed column per MIX cycle.
  // NOTE: the 128-bit registers are ordinary flops, not a memory array, so
  // they take the async reset and a reset never exposes stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_data  <= '0;
      r_out_data <= '0;
      r_col_idx  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            if (w_bypass) r_out_data <= in_data;
            else          r_in_data  <= in_data;
            r_col_idx <= '0;
          end
        end
        S_MIX: begin
          r_out_data[w_col_base +: COL_W] <= w_col_mixed;
          r_col_idx                       <= r_col_idx + CIDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign busy      = w_busy;
  assign out_data  = r_out_data;

endmodule
